// File: rtl/dualport_pkg.sv
// rtl/dualport_pkg.sv - shared FSM encoding and collision-mode constants for dualport_ram_ext
package dualport_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int COLL_READ_OLD      = 0;
    localparam int COLL_WRITE_THROUGH = 1;

endpackage

// File: rtl/dualport_rd_pipe.sv
// rtl/dualport_rd_pipe.sv - 1- or 2-stage read data/valid/err pipeline with held data
module dualport_rd_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_err,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             rd_err
);

    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;
    logic             s1_err;

    // First stage: data only moves on a completing read, so the output holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s1_err   <= in_err;
            if (in_valid) begin
                s1_data <= in_data;
            end
        end
    end

    if (LATENCY == 1) begin : g_lat1
        assign data_out = s1_data;
        assign rd_valid = s1_valid;
        assign rd_err   = s1_err;
    end else begin : g_lat2
        logic [WIDTH-1:0] s2_data;
        logic             s2_valid;
        logic             s2_err;

        // Second stage: same hold-on-idle behaviour as the first.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                s2_err   <= s1_err;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign data_out = s2_data;
        assign rd_valid = s2_valid;
        assign rd_err   = s2_err;
    end

endmodule

// File: rtl/dualport_ram_ext.sv
// rtl/dualport_ram_ext.sv - byte-enabled RAM with range check, collision mode and clear sequencer
module dualport_ram_ext
    import dualport_pkg::*;
#(
    parameter int   WIDTH          = 8,
    parameter int   DEPTH          = 16,
    parameter int   READ_LATENCY   = 1,
    parameter int   COLLISION_MODE = 0,
    localparam int  ADDR_W         = $clog2(DEPTH),
    localparam int  NBYTES         = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [NBYTES-1:0] wr_be,
    input  logic              read,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              clear,
    output logic              busy
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] clr_addr;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic              collide;
    logic [WIDTH-1:0]  wr_old;
    logic [WIDTH-1:0]  wr_word;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  fwd_word;
    logic [WIDTH-1:0]  rd_data;

    assign busy        = (state == ST_CLEAR);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_ok       = write && !busy && wr_in_range;
    assign rd_ok       = read && !busy;
    assign collide     = wr_ok && (wr_addr == rd_addr);

    assign wr_old  = wr_in_range ? mem[wr_addr] : '0;
    assign rd_word = rd_in_range ? mem[rd_addr] : '0;

    // Byte-enable merge for the stored word and for the write-through forwarding path.
    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
        assign wr_word[b*8 +: 8]  = wr_be[b] ? data_in[b*8 +: 8] : wr_old[b*8 +: 8];
        assign fwd_word[b*8 +: 8] = wr_be[b] ? data_in[b*8 +: 8] : rd_word[b*8 +: 8];
    end

    assign rd_data = (COLLISION_MODE == COLL_WRITE_THROUGH && collide) ? fwd_word : rd_word;

    // Single write port shared by the clear walker and user writes; busy keeps them exclusive.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // Clear sequencer: walks 0..DEPTH-1 once after reset and once per accepted clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    dualport_rd_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_ok),
        .in_err   (rd_ok && !rd_in_range),
        .in_data  (rd_data),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .rd_err   (rd_err)
    );

endmodule

// File: doc/dualport_ram_ext.md
DUALPORT_RAM_EXT -- requirements
Module: dualport_ram_ext

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (multiple of 8).
REQ-002 SHALL provide parameter DEPTH, default 16, number of words (2..4096, need not be a power of two).
REQ-003 SHALL provide parameter READ_LATENCY, default 1, cycles from read sample to data_out (1 or 2 only).
REQ-004 SHALL provide parameter COLLISION_MODE, default 0: 0 = read-old, 1 = write-through on same-address read/write.
REQ-005 SHALL derive localparam ADDR_W = $clog2(DEPTH) and NBYTES = WIDTH/8.
REQ-006 SHALL have ports: clk input 1, the only clock, rising edge; rst input 1, asynchronous active-high reset.
REQ-007 SHALL have ports: write input 1, write strobe; wr_addr input ADDR_W, write address; data_in input WIDTH, write data; wr_be input NBYTES, byte enables.
REQ-008 SHALL have ports: read input 1, read strobe; rd_addr input ADDR_W, read address.
REQ-009 SHALL have ports: data_out output WIDTH, read data; rd_valid output 1, data_out-valid pulse; rd_err output 1, out-of-range pulse.
REQ-010 SHALL have ports: clear input 1, clear request; busy output 1, clear sequence active.

Function
REQ-011 SHALL sample write, read and clear on every rising clk edge.
REQ-012 SHALL write data_in byte k to mem[wr_addr] only where wr_be[k]=1, when write=1, busy=0 and wr_addr<DEPTH.
REQ-013 SHALL ignore writes with wr_addr>=DEPTH.
REQ-014 SHALL present mem[rd_addr] on data_out with rd_valid=1 exactly READ_LATENCY cycles after read=1 with busy=0.
REQ-015 SHALL sustain one read per cycle, back to back, at either latency.
REQ-016 SHALL hold data_out at its last value and drive rd_valid=0 in cycles with no completing read.
REQ-017 SHALL, for rd_addr>=DEPTH, return data_out=0 with rd_valid=1 and rd_err=1 at the same latency.
REQ-018 SHALL, on same-cycle read and write to one address, return pre-write data if COLLISION_MODE=0.
REQ-019 SHALL, in that case with COLLISION_MODE=1, return old data with the enabled bytes replaced by data_in.
REQ-020 SHALL implement FSM {CLEAR, IDLE}: CLEAR writes 0 to one address per cycle from 0 up to DEPTH-1, then enters IDLE.
REQ-021 SHALL enter CLEAR from IDLE when clear=1, restarting at address 0.
REQ-022 SHALL ignore clear while already in CLEAR.
REQ-023 SHALL assert busy=1 exactly while in CLEAR, i.e. DEPTH cycles.
REQ-024 SHALL ignore write and read strobes while busy=1: no memory update, no rd_valid.
REQ-025 SHALL complete reads already in the pipeline when clear is accepted.

Reset
REQ-026 SHALL, on rst=1 regardless of clk: data_out=0, rd_valid=0, rd_err=0, pipeline flushed, FSM=CLEAR, clear address=0, busy=1.
REQ-027 SHALL begin the clear sequence on the first rising edge after rst deasserts, so memory reads 0 after reset.
REQ-028 SHALL abandon any in-flight read or clear on rst assertion mid-operation.

Structure
REQ-029 SHALL place FSM state encoding and the COLLISION_MODE constants in shared package dualport_pkg.
REQ-030 SHALL instantiate one sub-module, dualport_rd_pipe, holding the READ_LATENCY-deep data/valid/err pipeline.
REQ-031 SHALL keep memory array, byte-enable merge, collision mux and FSM in dualport_ram_ext, no latches.

Verification
REQ-032 SHALL check reset/clear: rst pulse -> busy=1 for 16 cycles, then reads of addr 0..15 return 8'h00.
REQ-033 SHALL check write/read: write 8'hA5 @3, read @3 -> data_out=8'hA5, rd_valid=1 after READ_LATENCY (run with both 1 and 2).
REQ-034 SHALL check byte enables: WIDTH=16, write 16'h1234 be=2'b11, then 16'hABCD be=2'b01 @5 -> read 16'h12CD.
REQ-035 SHALL check collision: mem[7]=8'h11, same-cycle write 8'h22 and read @7 -> 8'h11 (mode 0), 8'h22 (mode 1).
REQ-036 SHALL check range/clear: DEPTH=12, read @13 -> data_out=0, rd_err=1; clear mid-stream -> busy 12 cycles, writes ignored, contents 0.
